// File: rtl/i2s_tx_pkg.sv
// Shared types and defaults for the I2S transmit serializer.
package i2s_tx_pkg;
  localparam int unsigned I2S_SAMPLE_W = 16;
  localparam int unsigned I2S_SLOT_W   = 32;
  localparam int unsigned I2S_DELAY    = 1;

  typedef struct packed {
    logic signed [I2S_SAMPLE_W-1:0] l;
    logic signed [I2S_SAMPLE_W-1:0] r;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_tx_serializer_fifo.sv
// Small FIFO for stereo sample pairs; head word is readable combinationally.
module sample_fifo
  import i2s_tx_pkg::*;
#(
  parameter  int unsigned WIDTH = 2 * I2S_SAMPLE_W,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             AUD_CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W:0]   level_nxt;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)
      level_nxt = level + 1'b1;
    else if (!do_push && do_pop)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge AUD_CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (PTR_W+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge AUD_CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter for the WM8731 DAC: buffers stereo pairs and shifts them out MSB first.
// Optional build macro I2S_TX_ATTEN_EN adds an ATTEN[2:0] arithmetic right-shift at frame load.
module i2s_tx_serializer
  import i2s_tx_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = I2S_SAMPLE_W,
  parameter int unsigned SLOT_W     = I2S_SLOT_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        AUD_CLK,
  input  logic                        RESET,
  input  logic [SAMPLE_W-1:0]         SAMPLE_L,
  input  logic [SAMPLE_W-1:0]         SAMPLE_R,
  input  logic                        SAMPLE_VALID,
  output logic                        SAMPLE_READY,
`ifdef I2S_TX_ATTEN_EN
  input  logic [2:0]                  ATTEN,
`endif
  output logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  output logic                        UNDERRUN,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);
  localparam int unsigned FRAME = 2 * SLOT_W;
  localparam int unsigned BC_W  = $clog2(FRAME);
  localparam int unsigned IDX_W = $clog2(SAMPLE_W);
  localparam logic [BC_W-1:0] LAST = BC_W'(FRAME - 1);

  logic [BC_W-1:0]            bc;
  logic [BC_W-1:0]            bc_nxt;
  logic signed [SAMPLE_W-1:0] fl;
  logic signed [SAMPLE_W-1:0] fr;
  logic signed [SAMPLE_W-1:0] fl_ld;
  logic signed [SAMPLE_W-1:0] fr_ld;
  logic [2*SAMPLE_W-1:0]      head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       rst_q;
  logic                       load;
  logic                       dat_nxt;
  logic                       lrck_nxt;

  sample_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .AUD_CLK (AUD_CLK),
    .RESET   (RESET),
    .push    (SAMPLE_VALID && SAMPLE_READY),
    .pop     (load),
    .wdata   ({SAMPLE_L, SAMPLE_R}),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (FIFO_LEVEL)
  );

  assign load         = (bc == LAST);
  assign UNDERRUN     = load && fifo_empty;
  assign SAMPLE_READY = !fifo_full && !rst_q;
  assign bc_nxt       = load ? '0 : bc + 1'b1;

  always_comb begin
    fl_ld = '0;
    fr_ld = '0;
    if (!fifo_empty) begin
`ifdef I2S_TX_ATTEN_EN
      fl_ld = $signed(head[2*SAMPLE_W-1:SAMPLE_W]) >>> ATTEN;
      fr_ld = $signed(head[SAMPLE_W-1:0]) >>> ATTEN;
`else
      fl_ld = head[2*SAMPLE_W-1:SAMPLE_W];
      fr_ld = head[SAMPLE_W-1:0];
`endif
    end
  end

  // Output registers are fed from bc_nxt so the pins present the bit for the current bc.
  always_comb begin
    lrck_nxt = (bc_nxt >= BC_W'(SLOT_W));
    dat_nxt  = 1'b0;
    if (bc_nxt >= BC_W'(I2S_DELAY) && bc_nxt < BC_W'(SAMPLE_W + I2S_DELAY))
      dat_nxt = fl[IDX_W'(SAMPLE_W - 1 + I2S_DELAY - int'(bc_nxt))];
    else if (bc_nxt >= BC_W'(SLOT_W + I2S_DELAY) &&
             bc_nxt <  BC_W'(SLOT_W + SAMPLE_W + I2S_DELAY))
      dat_nxt = fr[IDX_W'(SLOT_W + SAMPLE_W - 1 + I2S_DELAY - int'(bc_nxt))];
  end

  always_ff @(posedge AUD_CLK) begin
    if (RESET) begin
      bc          <= '0;
      fl          <= '0;
      fr          <= '0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      rst_q       <= 1'b1;
    end else begin
      bc          <= bc_nxt;
      AUD_DACLRCK <= lrck_nxt;
      AUD_DACDAT  <= dat_nxt;
      rst_q       <= 1'b0;
      if (load) begin
        fl <= fl_ld;
        fr <= fr_ld;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: accepted pairs queue up as expected frames, a negedge monitor checks every bit.
module tb_i2s_tx_serializer;
  import i2s_tx_pkg::*;

  logic        AUD_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] SAMPLE_L = '0;
  logic [15:0] SAMPLE_R = '0;
  logic        SAMPLE_VALID = 1'b0;
  logic        SAMPLE_READY;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic        UNDERRUN;
  logic [2:0]  FIFO_LEVEL;
  logic [2:0]  atten_tb = '0;

  i2s_tx_serializer #(
    .SAMPLE_W   (16),
    .SLOT_W     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .AUD_CLK      (AUD_CLK),
    .RESET        (RESET),
    .SAMPLE_L     (SAMPLE_L),
    .SAMPLE_R     (SAMPLE_R),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
`ifdef I2S_TX_ATTEN_EN
    .ATTEN        (atten_tb),
`endif
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .UNDERRUN     (UNDERRUN),
    .FIFO_LEVEL   (FIFO_LEVEL)
  );

  always #5 AUD_CLK = ~AUD_CLK;

  int checks = 0;
  int errors = 0;
  int und_cnt = 0;

  stereo_sample_t exp_q[$];
  stereo_sample_t cur = '0;
  int             k = 0;
  bit             rdy_m = 1'b0;
  logic [15:0]    cap_l = '0;
  logic [15:0]    cap_r = '0;
  logic [31:0]    played_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t k=%0d)", name, act, exp, $time, k);
    end
  endtask

  task automatic wait_k(input int t);
    int n = 0;
    do begin
      @(negedge AUD_CLK);
      n++;
    end while (k != t && n < 200);
    if (k != t) begin
      checks++;
      errors++;
      $display("FAIL wait_k actual k=%0d required=%0d", k, t);
    end
  endtask

  // Reference model: acceptance, FIFO order, frame load and bit position.
  always @(posedge AUD_CLK) begin
    stereo_sample_t p;
    bit acc;
    if (RESET) begin
      exp_q.delete();
      k     = 0;
      cur   = '0;
      rdy_m = 1'b0;
    end else begin
      acc = SAMPLE_VALID && rdy_m;
      if (k == 63) begin
        if (exp_q.size() == 0) cur = '0;
        else begin
          p     = exp_q.pop_front();
          cur.l = p.l >>> atten_tb;
          cur.r = p.r >>> atten_tb;
        end
      end
      if (acc) exp_q.push_back({SAMPLE_L, SAMPLE_R});
      k     = (k == 63) ? 0 : k + 1;
      rdy_m = (exp_q.size() < 4);
    end
  end

  always @(negedge AUD_CLK) begin
    logic e;
    e = 1'b0;
    if (k >= 1 && k <= 16)       e = cur.l[4'(16 - k)];
    else if (k >= 33 && k <= 48) e = cur.r[4'(48 - k)];
    chk("lrck", AUD_DACLRCK, (k >= 32));
    chk("dat", AUD_DACDAT, e);
    chk("underrun", UNDERRUN, (k == 63 && exp_q.size() == 0));
    chk("ready", SAMPLE_READY, rdy_m);
    chk("level", FIFO_LEVEL, exp_q.size());
    if (UNDERRUN) und_cnt++;
    if (k >= 1 && k <= 16)  cap_l = {cap_l[14:0], AUD_DACDAT};
    if (k >= 33 && k <= 48) cap_r = {cap_r[14:0], AUD_DACDAT};
    if (k == 63) played_q.push_back({cap_l, cap_r});
  end

  stereo_sample_t pairs [6] = '{
    '{16'h1234, 16'hFEDC}, '{16'h0001, 16'h8000}, '{16'h7FFF, 16'h0F0F},
    '{16'hCAFE, 16'hBEEF}, '{16'h5555, 16'hAAAA}, '{16'h00FF, 16'hFF00}
  };

  initial begin
    int  und0;
    int  i;
    logic rd;

    // Reset held for three cycles.
    repeat (3) @(negedge AUD_CLK);
    chk("rst_ready", SAMPLE_READY, 1'b0);
    chk("rst_level", FIFO_LEVEL, 3'd0);
    chk("rst_dat", AUD_DACDAT, 1'b0);
    chk("rst_lrck", AUD_DACLRCK, 1'b0);
    RESET = 1'b0;
    und0  = und_cnt;

    // Three idle frames: one underrun each.
    repeat (192) @(negedge AUD_CLK);
    #1 chk("idle_underruns", und_cnt - und0, 3);

    // Single pair plays in the next frame.
    wait_k(1);
    played_q.delete();
    SAMPLE_L = 16'hA5C3; SAMPLE_R = 16'h8001; SAMPLE_VALID = 1'b1;
    @(negedge AUD_CLK);
    SAMPLE_VALID = 1'b0;
    wait_k(63);
    #1 chk("a5c3_no_underrun", UNDERRUN, 1'b0);
    wait_k(63);
    #1;
    chk("a5c3_frames", played_q.size(), 2);
    chk("a5c3_frame0", played_q[0], 32'h0000_0000);
    chk("a5c3_frame1", played_q[1], 32'hA5C3_8001);

    // Held VALID with six pairs: FIFO fills, then drains one per frame.
    wait_k(1);
    played_q.delete();
    i = 0;
    SAMPLE_VALID = 1'b1;
    {SAMPLE_L, SAMPLE_R} = pairs[0];
    for (int c = 0; c < 600 && i < 6; c++) begin
      rd = SAMPLE_READY;
      @(negedge AUD_CLK);
      if (rd) begin
        i++;
        if (i == 4) begin
          chk("full_level", FIFO_LEVEL, 3'd4);
          chk("full_ready", SAMPLE_READY, 1'b0);
        end
        if (i < 6) {SAMPLE_L, SAMPLE_R} = pairs[i];
        else SAMPLE_VALID = 1'b0;
      end
    end
    SAMPLE_VALID = 1'b0;
    chk("hold_accepts", i, 6);
    repeat (400) @(negedge AUD_CLK);
    #1;
    chk("hold_frames_ge7", (played_q.size() >= 7), 1'b1);
    if (played_q.size() >= 7) begin
      chk("hold_frame0", played_q[0], 32'h0);
      for (int j = 0; j < 6; j++) chk($sformatf("hold_pair%0d", j), played_q[j+1], pairs[j]);
    end

    // Push coincident with the load cycle while empty.
    wait_k(63);
    SAMPLE_L = 16'h3C3C; SAMPLE_R = 16'hC3C3; SAMPLE_VALID = 1'b1;
    #1 chk("coinc_underrun", UNDERRUN, 1'b1);
    played_q.delete();
    @(negedge AUD_CLK);
    SAMPLE_VALID = 1'b0;
    wait_k(63);
    wait_k(63);
    #1;
    chk("coinc_frames", played_q.size(), 2);
    chk("coinc_zero", played_q[0], 32'h0);
    chk("coinc_pair", played_q[1], 32'h3C3C_C3C3);

    // Reset in the middle of a non-zero frame with data still queued.
    wait_k(1);
    SAMPLE_L = 16'hFFFF; SAMPLE_R = 16'hFFFF; SAMPLE_VALID = 1'b1;
    @(negedge AUD_CLK);
    SAMPLE_L = 16'h1357; SAMPLE_R = 16'h2468;
    @(negedge AUD_CLK);
    SAMPLE_VALID = 1'b0;
    wait_k(63);
    wait_k(20);
    chk("mid_level_before", FIFO_LEVEL, 3'd1);
    RESET = 1'b1;
    @(negedge AUD_CLK);
    chk("mid_lrck", AUD_DACLRCK, 1'b0);
    chk("mid_dat", AUD_DACDAT, 1'b0);
    chk("mid_level", FIFO_LEVEL, 3'd0);
    chk("mid_ready", SAMPLE_READY, 1'b0);
    RESET = 1'b0;
    repeat (70) @(negedge AUD_CLK);

`ifdef I2S_TX_ATTEN_EN
    // Attenuation by 2: 8000 -> E000, 7FFF -> 1FFF.
    atten_tb = 3'd2;
    wait_k(1);
    played_q.delete();
    SAMPLE_L = 16'h8000; SAMPLE_R = 16'h7FFF; SAMPLE_VALID = 1'b1;
    @(negedge AUD_CLK);
    SAMPLE_VALID = 1'b0;
    wait_k(63);
    wait_k(63);
    #1;
    chk("atten_frames", played_q.size(), 2);
    chk("atten_pair", played_q[1], 32'hE000_1FFF);
    atten_tb = 3'd0;
`endif

    repeat (10) @(negedge AUD_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
